fma_issue_retire: RTL

FMA_ISSUE_RETIRE -- requirements
Module: fma_issue_retire

---
 rtl/fma_issue_retire.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fma_issue_retire.sv
`default_nettype none
// ==== fma_issue_retire : FP32 FMA issue stage with in-order result queue ====
// ==== Rev 1.0                                                             ====
module fma_issue_retire #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  output logic        in_ready,
  output logic        iss_valid,
  output logic [31:0] iss_a,
  output logic [31:0] iss_b,
  output logic [31:0] iss_c,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [3:0]  out_tag,
  input  logic        out_ready,
  output logic [1:0]  err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 1) begin : g_bad_params
    $error("fma_issue_retire: unsupported DEPTH or LATENCY");
  end

  logic [CNT_W-1:0] inflight_q, inflight_d, count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]       tag_q, tag_d;
  logic [1:0]       err_q, err_d;
  logic             iss_valid_q, iss_valid_d;
  logic [31:0]      iss_a_q, iss_a_d, iss_b_q, iss_b_d, iss_c_q, iss_c_d;
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic             accept, pop, push, spurious, retire, overflow;

  // Reserve a queue slot for every operation in flight so results never overflow.
  assign in_ready = ({1'b0, inflight_q} + {1'b0, count_q}) < {1'b0, FULL};

  always_comb begin
    accept   = in_valid && in_ready;
    pop      = (count_q != '0) && out_ready;
    spurious = res_valid && (inflight_q == '0);
    retire   = res_valid && !spurious;
    overflow = retire && (count_q == FULL) && !pop;
    push     = retire && !overflow;

    inflight_d = inflight_q;
    if (accept && !retire)      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && retire) inflight_d = inflight_q - CNT_W'(1);

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = res_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    rd_ptr_d = rd_ptr_q;
    tag_d    = tag_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      tag_d    = tag_q + 4'd1;
    end

    err_d       = err_q | {spurious, overflow};
    iss_valid_d = accept;
    iss_a_d     = accept ? in_a : iss_a_q;
    iss_b_d     = accept ? in_b : iss_b_q;
    iss_c_d     = accept ? in_c : iss_c_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_q       <= '0;
      err_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_c_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
      iss_valid_q <= iss_valid_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_c_q     <= iss_c_d;
      mem_q       <= mem_d;
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_a     = iss_a_q;
  assign iss_b     = iss_b_q;
  assign iss_c     = iss_c_q;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign out_tag   = tag_q;
  assign err       = err_q;
endmodule
`default_nettype wire
